// File: rtl/word_assembler_if.sv
// ============================================================================
//  Module      : word_assembler_if
//  Description : Handshake bundle for the byte-to-word assembler. Carries the
//                upstream byte stream, the downstream 32-bit word stream, the
//                occupancy count and, when ASSEMBLER_FLUSH_EN is defined, the
//                flush request.
//  Modports    : master - the side that sources bytes and sinks words
//                slave  - the assembler itself
//  Signals     : in_data[7:0], in_valid, in_ready   byte stream
//                out_data[31:0], out_valid, out_ready word stream
//                byte_cnt[2:0]                      bytes held (0..4)
//                flush                              ASSEMBLER_FLUSH_EN only
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface word_assembler_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  byte_cnt;
`ifdef ASSEMBLER_FLUSH_EN
  logic        flush;
`endif

`ifdef ASSEMBLER_FLUSH_EN
  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, byte_cnt
  );
  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, byte_cnt
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, byte_cnt
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, byte_cnt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
//  Module      : word_assembler
//  Description : Packs a stream of bytes into 32-bit words, MSB first (byte 0
//                lands in bits [31:24]). A completed word is held on out_data
//                with out_valid until the consumer takes it; a byte offered in
//                the same cycle the word retires starts the next word with no
//                bubble.
//  Ports       : clk      - single clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - word_assembler_if.slave (byte in, word out,
//                           byte_cnt, optional flush)
//  Options     : ASSEMBLER_FLUSH_EN - adds the flush input, which emits a
//                partially filled word (unfilled low bytes read as zero).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module word_assembler (
  input logic             clk,
  input logic             reset_n,
  word_assembler_if.slave bus
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_data;
  logic [31:0] w_data_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_retire;
  logic [31:0] w_byte_placed;

  // A held word blocks new bytes unless it is leaving this same cycle.
  assign w_in_ready = (r_state != ST_FULL) || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_retire   = (r_state == ST_FULL) && bus.out_ready;

  // Incoming byte positioned at the slot selected by the current count.
  // Only used in COLLECT, where the count never exceeds 3.
  always_comb begin
    w_byte_placed = '0;
    case (r_cnt[1:0])
      2'd0:    w_byte_placed[31:24] = bus.in_data;
      2'd1:    w_byte_placed[23:16] = bus.in_data;
      2'd2:    w_byte_placed[15:8]  = bus.in_data;
      default: w_byte_placed[7:0]   = bus.in_data;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_COLLECT: begin
        if (w_accept) begin
          // Unwritten slots are already zero, so OR-ing in is sufficient.
          w_data_nxt = r_data | w_byte_placed;
          w_cnt_nxt  = r_cnt + 3'd1;
          if (r_cnt == 3'd3) begin
            w_state_nxt = ST_FULL;
          end
        end
`ifdef ASSEMBLER_FLUSH_EN
        // Flush looks at the count after this edge's byte, so a lone first
        // byte plus flush still emits, and an empty word never does.
        if (bus.flush && (w_cnt_nxt != 3'd0)) begin
          w_state_nxt = ST_FULL;
        end
`endif
      end
      ST_FULL: begin
        if (w_retire) begin
          w_state_nxt = ST_COLLECT;
          if (w_accept) begin
            w_data_nxt = {bus.in_data, 24'h00_0000};
            w_cnt_nxt  = 3'd1;
          end else begin
            w_data_nxt = '0;
            w_cnt_nxt  = 3'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_COLLECT;
        w_data_nxt  = '0;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_COLLECT;
      r_data  <= '0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_data;
  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.byte_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 Parameters: none; word width fixed at 32 bits, byte width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  8  byte from upstream serial source.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts a byte this cycle; transfer when in_valid && in_ready.
REQ-007 out_data  output  32  assembled word; drives the byte-splitter input A directly.
REQ-008 out_valid  output  1  out_data holds a complete (or flushed) word.
REQ-009 out_ready  input  1  downstream consumes word; transfer when out_valid && out_ready.
REQ-010 byte_cnt  output  3  bytes held in the current word, 0..4.
REQ-011 flush  input  1  present only with ASSEMBLER_FLUSH_EN; emit the partial word.

Function
REQ-012 States SHALL be COLLECT (out_valid=0, byte_cnt 0..3) and FULL (out_valid=1).
REQ-013 Byte order SHALL be MSB-first: byte k of a word (k=0..3) lands in out_data[31-8k:24-8k], so first byte appears on splitter O1, last on O4.
REQ-014 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-015 In COLLECT, each accepted byte SHALL be written to slot byte_cnt, and byte_cnt SHALL increment by 1.
REQ-016 On acceptance of the 4th byte at edge N, state SHALL be FULL, out_valid=1, byte_cnt=4 from edge N onward (latency 1 edge, registered outputs).
REQ-017 In FULL, out_data and out_valid SHALL hold stable until out_valid && out_ready.
REQ-018 On out_ready in FULL with no byte accepted: state to COLLECT, byte_cnt=0, out_data cleared to 0.
REQ-019 Simultaneous word handoff and byte accept in FULL: word retires, accepted byte SHALL become byte 0 of the next word (out_data=in_data<<24, byte_cnt=1, COLLECT); no bubble.
REQ-020 Unwritten slots of a word in progress SHALL read as 0.
REQ-021 in_data SHALL be ignored when in_valid=0 or in_ready=0; no state change.
REQ-022 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-023 reset_n low SHALL immediately force out_data=0, out_valid=0, byte_cnt=0, state COLLECT, regardless of clk.
REQ-024 Reset mid-word or while FULL SHALL discard the partial/complete word; first byte after reset release is byte 0.
REQ-025 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-026 Macro ASSEMBLER_FLUSH_EN SHALL compile in the flush port and logic.
REQ-027 With ASSEMBLER_FLUSH_EN: flush=1 in COLLECT with byte_cnt>0 (after counting any byte accepted that edge) SHALL move to FULL with current byte_cnt, unfilled low slots 0.
REQ-028 With ASSEMBLER_FLUSH_EN: flush with byte_cnt=0, or in FULL, SHALL be ignored; flush coinciding with a 4th byte yields a normal full word.
REQ-029 Without ASSEMBLER_FLUSH_EN: no flush port; out_valid asserts only with byte_cnt=4.

Verification
REQ-030 Bytes 0x12,0x34,0x56,0x78 on consecutive cycles, out_ready=1 -> out_data=0x12345678, out_valid=1 one edge after 0x78, byte_cnt=4.
REQ-031 Word held with out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, out_data stable 0xAABBCCDD, extra byte not consumed until out_ready=1.
REQ-032 FULL with 0x01020304, out_ready=1 and in_valid=1 in_data=0x9A same cycle -> next cycle out_valid=0, out_data=0x9A000000, byte_cnt=1.
REQ-033 Two bytes 0xDE,0xAD, reset_n pulsed low between clock edges -> out_data=0, byte_cnt=0 at once; next bytes 0x11..0x44 yield 0x11223344.
REQ-034 ASSEMBLER_FLUSH_EN: bytes 0xCA,0xFE then flush=1 -> out_data=0xCAFE0000, out_valid=1, byte_cnt=2; flush with byte_cnt=0 -> no output.
